// File: rtl/bcd_digit_renderer.sv
// Renders an 8-bit value as two 5x8 font digits on a PCD8544 LCD: requests a BCD
// conversion, then streams set-X, set-Y and 12 glyph column bytes over valid/ready.
module bcd_digit_renderer #(
   parameter int unsigned X_POS         = 0,
   parameter int unsigned Y_BANK        = 0,
   parameter bit          LEADING_BLANK = 1'b1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] value,
   input  logic       update,
   output logic       bcd_start,
   output logic [7:0] bcd_value,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_ones,
   input  logic       bcd_done,
   output logic [7:0] tx_data,
   output logic       tx_dc,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WCLR,
      S_CMDX,
      S_CMDY,
      S_DATA,
      S_FIN
   } state_t;

   localparam logic [7:0] CMD_X       = {1'b1, 7'(X_POS)};
   localparam logic [7:0] CMD_Y       = {5'b01000, 3'(Y_BANK)};
   localparam logic [3:0] GLYPH_BLANK = 4'd15;
   localparam logic [3:0] COL_LAST    = 4'd11;

   function automatic logic [6:0] sat99(input logic [7:0] v);
      logic [6:0] r;
      if (v > 8'd99) begin
         r = 7'd99;
      end else begin
         r = v[6:0];
      end
      return r;
   endfunction

   // Glyphs are stored in reading order: column 0 is the most significant byte.
   function automatic logic [39:0] glyph_bits(input logic [3:0] digit);
      logic [39:0] g;
      case (digit)
         4'd0:    g = 40'h3E_51_49_45_3E;
         4'd1:    g = 40'h00_42_7F_40_00;
         4'd2:    g = 40'h42_61_51_49_46;
         4'd3:    g = 40'h21_41_45_4B_31;
         4'd4:    g = 40'h18_14_12_7F_10;
         4'd5:    g = 40'h27_45_45_45_39;
         4'd6:    g = 40'h3C_4A_49_49_30;
         4'd7:    g = 40'h01_71_09_05_03;
         4'd8:    g = 40'h36_49_49_49_36;
         4'd9:    g = 40'h06_49_49_29_1E;
         default: g = 40'h00_00_00_00_00;
      endcase
      return g;
   endfunction

   function automatic logic [7:0] glyph_col(input logic [3:0] digit, input logic [2:0] col);
      logic [39:0] g;
      logic [7:0]  b;
      g = glyph_bits(digit);
      case (col)
         3'd0:    b = g[39:32];
         3'd1:    b = g[31:24];
         3'd2:    b = g[23:16];
         3'd3:    b = g[15:8];
         default: b = g[7:0];
      endcase
      return b;
   endfunction

   state_t     state_q, state_d;
   logic [6:0] val_q, val_d;
   logic       pend_q, pend_d;
   logic [6:0] pend_val_q, pend_val_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic [3:0] col_q, col_d;
   logic [3:0] tens_code;
   logic [7:0] data_byte;

   assign bcd_value = {1'b0, val_q};

   // Column 5 and 11 are the one-pixel spacers after each glyph.
   always_comb begin
      tens_code = (LEADING_BLANK && (tens_q == 4'd0)) ? GLYPH_BLANK : tens_q;
      case (col_q)
         4'd0:    data_byte = glyph_col(tens_code, 3'd0);
         4'd1:    data_byte = glyph_col(tens_code, 3'd1);
         4'd2:    data_byte = glyph_col(tens_code, 3'd2);
         4'd3:    data_byte = glyph_col(tens_code, 3'd3);
         4'd4:    data_byte = glyph_col(tens_code, 3'd4);
         4'd6:    data_byte = glyph_col(ones_q, 3'd0);
         4'd7:    data_byte = glyph_col(ones_q, 3'd1);
         4'd8:    data_byte = glyph_col(ones_q, 3'd2);
         4'd9:    data_byte = glyph_col(ones_q, 3'd3);
         4'd10:   data_byte = glyph_col(ones_q, 3'd4);
         default: data_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      val_d      = val_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      col_d      = col_q;
      bcd_start  = 1'b0;
      tx_valid   = 1'b0;
      tx_dc      = 1'b0;
      tx_data    = 8'h00;
      busy       = 1'b1;

      // Requests arriving mid-frame collapse into one pending slot; newest wins.
      if (update && (state_q != S_IDLE) && (state_q != S_FIN)) begin
         pend_d     = 1'b1;
         pend_val_d = sat99(value);
      end

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (update) begin
               val_d   = sat99(value);
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            bcd_start = 1'b1;
            if (bcd_done) begin
               tens_d  = bcd_tens;
               ones_d  = bcd_ones;
               state_d = S_WCLR;
            end
         end
         S_WCLR: begin
            if (!bcd_done) begin
               state_d = S_CMDX;
            end
         end
         S_CMDX: begin
            tx_valid = 1'b1;
            tx_data  = CMD_X;
            if (tx_ready) begin
               state_d = S_CMDY;
            end
         end
         S_CMDY: begin
            tx_valid = 1'b1;
            tx_data  = CMD_Y;
            if (tx_ready) begin
               col_d   = 4'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_dc    = 1'b1;
            tx_data  = data_byte;
            if (tx_ready) begin
               if (col_q == COL_LAST) begin
                  col_d   = 4'd0;
                  state_d = S_FIN;
               end else begin
                  col_d = col_q + 4'd1;
               end
            end
         end
         S_FIN: begin
            busy = 1'b0;
            // An update landing here counts as pending and is served right away.
            if (update) begin
               val_d   = sat99(value);
               pend_d  = 1'b0;
               state_d = S_REQ;
            end else if (pend_q) begin
               val_d   = pend_val_q;
               pend_d  = 1'b0;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         val_q   <= 7'd0;
         pend_q  <= 1'b0;
         col_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         pend_q  <= pend_d;
         col_q   <= col_d;
      end
   end

   // Digit and pending-value payloads are only read behind valid control state.
   always_ff @(posedge clk) begin
      pend_val_q <= pend_val_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
   end

endmodule

// File: tb/tb_bcd_digit_renderer.sv
// Scoreboard bench for bcd_digit_renderer: a converter model answers conversions,
// expected LCD bytes are queued per update and popped as transfers occur.
module tb_bcd_digit_renderer;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] value;
   logic       update;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       bcd_done;
   logic       tx_ready;

   logic       bcd_start_a, tx_dc_a, tx_valid_a, busy_a;
   logic [7:0] bcd_value_a, tx_data_a;
   logic       bcd_start_b, tx_dc_b, tx_valid_b, busy_b;
   logic [7:0] bcd_value_b, tx_data_b;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_a[$];
   logic [8:0] exp_b[$];
   int         xfer_a = 0;
   int         xfer_b = 0;
   int         conv_cnt = 0;
   int         conv_delay = 20;
   int         ccnt = 0;
   int         start_hold_err = 0;
   logic [7:0] last_conv_val = 8'd0;
   bit         rand_ready = 1'b0;
   logic       stall_a = 1'b0, stall_b = 1'b0;
   logic [8:0] held_a, held_b, got_a, got_b, e_a, e_b;

   always #5 clk = ~clk;

   bcd_digit_renderer dut_a (
      .clk(clk), .nrst(nrst), .value(value), .update(update),
      .bcd_start(bcd_start_a), .bcd_value(bcd_value_a),
      .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_done(bcd_done),
      .tx_data(tx_data_a), .tx_dc(tx_dc_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready), .busy(busy_a)
   );

   bcd_digit_renderer #(.X_POS(130), .Y_BANK(9), .LEADING_BLANK(1'b0)) dut_b (
      .clk(clk), .nrst(nrst), .value(value), .update(update),
      .bcd_start(bcd_start_b), .bcd_value(bcd_value_b),
      .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_done(bcd_done),
      .tx_data(tx_data_b), .tx_dc(tx_dc_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready), .busy(busy_b)
   );

   function automatic logic [7:0] font_col(input int d, input int c);
      logic [39:0] g;
      case (d)
         0:       g = 40'h3E_51_49_45_3E;
         1:       g = 40'h00_42_7F_40_00;
         2:       g = 40'h42_61_51_49_46;
         3:       g = 40'h21_41_45_4B_31;
         4:       g = 40'h18_14_12_7F_10;
         5:       g = 40'h27_45_45_45_39;
         6:       g = 40'h3C_4A_49_49_30;
         7:       g = 40'h01_71_09_05_03;
         8:       g = 40'h36_49_49_49_36;
         9:       g = 40'h06_49_49_29_1E;
         default: g = 40'h0;
      endcase
      return g[39-8*c -: 8];
   endfunction

   // dut_a: X=0, Y=0, leading blank on. dut_b: X=130->2, Y=9->1, leading blank off.
   task automatic push_frame(input int v);
      int cv, t, o;
      cv = (v > 99) ? 99 : v;
      t  = cv / 10;
      o  = cv % 10;
      exp_a.push_back({1'b0, 8'h80});
      exp_b.push_back({1'b0, 8'h82});
      exp_a.push_back({1'b0, 8'h40});
      exp_b.push_back({1'b0, 8'h41});
      for (int c = 0; c < 5; c++) begin
         exp_a.push_back({1'b1, ((t == 0) ? 8'h00 : font_col(t, c))});
         exp_b.push_back({1'b1, font_col(t, c)});
      end
      exp_a.push_back({1'b1, 8'h00});
      exp_b.push_back({1'b1, 8'h00});
      for (int c = 0; c < 5; c++) begin
         exp_a.push_back({1'b1, font_col(o, c)});
         exp_b.push_back({1'b1, font_col(o, c)});
      end
      exp_a.push_back({1'b1, 8'h00});
      exp_b.push_back({1'b1, 8'h00});
   endtask

   // Converter model: level start/done, answers after conv_delay cycles.
   initial begin
      bcd_done = 1'b0;
      bcd_tens = 4'd0;
      bcd_ones = 4'd0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            bcd_done = 1'b0;
            ccnt     = 0;
         end else if (bcd_done) begin
            if (bcd_start_a) start_hold_err++;
            else bcd_done = 1'b0;
         end else if (bcd_start_a) begin
            ccnt++;
            if (ccnt >= conv_delay) begin
               ccnt          = 0;
               last_conv_val = bcd_value_a;
               conv_cnt++;
               bcd_tens      = 4'(bcd_value_a / 10);
               bcd_ones      = 4'(bcd_value_a % 10);
               bcd_done      = 1'b1;
            end
         end
      end
   end

   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Transfer monitor: sampled mid-cycle, i.e. what the DUT sees at the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!nrst) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
         end else begin
            got_a = {tx_dc_a, tx_data_a};
            got_b = {tx_dc_b, tx_data_b};
            if (stall_a) begin
               checks++;
               if (!tx_valid_a || got_a !== held_a) begin
                  errors++;
                  $display("FAIL stall_hold_a: got valid=%0b %h, required valid=1 %h", tx_valid_a, got_a, held_a);
               end
            end
            if (stall_b) begin
               checks++;
               if (!tx_valid_b || got_b !== held_b) begin
                  errors++;
                  $display("FAIL stall_hold_b: got valid=%0b %h, required valid=1 %h", tx_valid_b, got_b, held_b);
               end
            end
            if (tx_valid_a && tx_ready) begin
               xfer_a++;
               checks++;
               if (exp_a.size() == 0) begin
                  errors++;
                  $display("FAIL extra_byte_a: got %h, required no transfer", got_a);
               end else begin
                  e_a = exp_a.pop_front();
                  if (got_a !== e_a || busy_a !== 1'b1) begin
                     errors++;
                     $display("FAIL byte_a: got dc/data %h busy %0b, required %h busy 1", got_a, busy_a, e_a);
                  end
               end
            end
            if (tx_valid_b && tx_ready) begin
               xfer_b++;
               checks++;
               if (exp_b.size() == 0) begin
                  errors++;
                  $display("FAIL extra_byte_b: got %h, required no transfer", got_b);
               end else begin
                  e_b = exp_b.pop_front();
                  if (got_b !== e_b || busy_b !== 1'b1) begin
                     errors++;
                     $display("FAIL byte_b: got dc/data %h busy %0b, required %h busy 1", got_b, busy_b, e_b);
                  end
               end
            end
            stall_a = tx_valid_a && !tx_ready;
            stall_b = tx_valid_b && !tx_ready;
            held_a  = got_a;
            held_b  = got_b;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic pulse_update(input logic [7:0] v);
      @(posedge clk);
      #1;
      value  = v;
      update = 1'b1;
      @(posedge clk);
      #1;
      update = 1'b0;
   endtask

   task automatic wait_xfer(input int target, input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (xfer_a < target && n < budget);
      checks++;
      if (xfer_a < target) begin
         errors++;
         $display("FAIL xfer_timeout: got %0d transfers, required %0d", xfer_a, target);
      end
   endtask

   task automatic wait_frame(input int budget);
      int quiet, n;
      quiet = 0;
      n     = 0;
      while (quiet < 3 && n < budget) begin
         @(posedge clk);
         #2;
         n++;
         if (exp_a.size() == 0 && exp_b.size() == 0 && !busy_a && !busy_b &&
             !bcd_start_a && !bcd_start_b) quiet++;
         else quiet = 0;
      end
      checks++;
      if (quiet < 3) begin
         errors++;
         $display("FAIL frame_timeout: got %0d/%0d bytes outstanding busy=%0b, required 0/0 busy=0",
                  exp_a.size(), exp_b.size(), busy_a);
      end
   endtask

   task automatic test_reset();
      nrst   = 1'b0;
      update = 1'b0;
      value  = 8'd0;
      #3;
      checks++;
      if ({bcd_start_a, tx_valid_a, tx_dc_a, busy_a, tx_data_a, bcd_value_a,
           bcd_start_b, tx_valid_b, tx_dc_b, busy_b, tx_data_b, bcd_value_b} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got data %h/%h valid %0b start %0b, required all 0",
                  tx_data_a, tx_data_b, tx_valid_a, bcd_start_a);
      end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({bcd_start_a, tx_valid_a, busy_a, tx_data_b, tx_valid_b} !== '0) begin
         errors++;
         $display("FAIL reset_held: got start %0b valid %0b busy %0b, required 0 0 0", bcd_start_a, tx_valid_a, busy_a);
      end
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({bcd_start_a, tx_valid_a, busy_a, bcd_value_a} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got start %0b valid %0b busy %0b, required 0 0 0", bcd_start_a, tx_valid_a, busy_a);
      end
   endtask

   task automatic test_basic();
      int base, c0, n;
      rand_ready = 1'b0;
      conv_delay = 20;
      base = xfer_a;
      c0   = conv_cnt;
      push_frame(42);
      pulse_update(8'd42);
      checks++;
      if (bcd_start_a !== 1'b1 || busy_a !== 1'b1 || tx_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL latency: got start %0b busy %0b valid %0b, required 1 1 0", bcd_start_a, busy_a, tx_valid_a);
      end
      wait_xfer(base + 1, 80, n);
      wait_xfer(base + 14, 40, n);
      checks++;
      if (n !== 13) begin
         errors++;
         $display("FAIL back_to_back_rate: got %0d cycles for 13 transfers, required 13", n);
      end
      #2;
      checks++;
      if (busy_a !== 1'b0 || tx_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL busy_fall: got busy %0b valid %0b, required 0 0", busy_a, tx_valid_a);
      end
      wait_frame(100);
      checks++;
      if (start_hold_err !== 0 || last_conv_val !== 8'd42 || conv_cnt !== c0 + 1) begin
         errors++;
         $display("FAIL basic_conv: got hold_err %0d value %0d convs %0d, required 0 42 %0d",
                  start_hold_err, last_conv_val, conv_cnt - c0, 1);
      end
   endtask

   task automatic test_leading_blank();
      int vals[3] = '{7, 0, 10};
      conv_delay = 5;
      foreach (vals[i]) begin
         push_frame(vals[i]);
         pulse_update(8'(vals[i]));
         wait_frame(200);
         checks++;
         if (last_conv_val !== 8'(vals[i])) begin
            errors++;
            $display("FAIL blank_conv: got %0d, required %0d", last_conv_val, vals[i]);
         end
      end
   endtask

   task automatic test_clamp();
      int vals[4] = '{200, 99, 100, 255};
      conv_delay = 4;
      foreach (vals[i]) begin
         push_frame(vals[i]);
         pulse_update(8'(vals[i]));
         wait_frame(200);
         checks++;
         if (last_conv_val !== 8'd99 || bcd_value_b !== 8'd99) begin
            errors++;
            $display("FAIL clamp: input %0d got %0d/%0d, required 99", vals[i], last_conv_val, bcd_value_b);
         end
      end
   endtask

   task automatic test_backpressure();
      int vals[3] = '{58, 81, 36};
      int ba, bb;
      conv_delay = 3;
      rand_ready = 1'b1;
      foreach (vals[i]) begin
         ba = xfer_a;
         bb = xfer_b;
         push_frame(vals[i]);
         pulse_update(8'(vals[i]));
         wait_frame(800);
         checks++;
         if (xfer_a - ba !== 14 || xfer_b - bb !== 14) begin
            errors++;
            $display("FAIL bp_count: got %0d/%0d transfers, required 14/14", xfer_a - ba, xfer_b - bb);
         end
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int base, c0, n;
      conv_delay = 5;
      base = xfer_a;
      c0   = conv_cnt;
      push_frame(42);
      push_frame(56);
      pulse_update(8'd42);
      wait_xfer(base + 4, 100, n);
      pulse_update(8'd12);
      pulse_update(8'd34);
      pulse_update(8'd56);
      wait_frame(400);
      checks++;
      if (conv_cnt - c0 !== 2 || last_conv_val !== 8'd56 || xfer_a - base !== 28) begin
         errors++;
         $display("FAIL pending: got convs %0d last %0d xfers %0d, required 2 56 28",
                  conv_cnt - c0, last_conv_val, xfer_a - base);
      end
   endtask

   task automatic test_fin_update();
      int base, c0, n;
      conv_delay = 4;
      base = xfer_a;
      c0   = conv_cnt;
      push_frame(9);
      push_frame(63);
      pulse_update(8'd9);
      wait_xfer(base + 14, 200, n);
      #1;
      value  = 8'd63;
      update = 1'b1;
      #1;
      checks++;
      if (busy_a !== 1'b0 || tx_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL fin_state: got busy %0b valid %0b, required 0 0", busy_a, tx_valid_a);
      end
      @(posedge clk);
      #1;
      update = 1'b0;
      checks++;
      if (bcd_start_a !== 1'b1 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL fin_update: got start %0b busy %0b, required 1 1", bcd_start_a, busy_a);
      end
      wait_frame(300);
      checks++;
      if (conv_cnt - c0 !== 2 || last_conv_val !== 8'd63) begin
         errors++;
         $display("FAIL fin_conv: got convs %0d last %0d, required 2 63", conv_cnt - c0, last_conv_val);
      end
   endtask

   task automatic test_reset_mid();
      int base, n;
      conv_delay = 6;
      base = xfer_a;
      push_frame(33);
      pulse_update(8'd33);
      wait_xfer(base + 6, 100, n);
      #1;
      nrst = 1'b0;
      #1;
      checks++;
      if ({bcd_start_a, tx_valid_a, tx_dc_a, busy_a, tx_data_a, bcd_value_a,
           tx_valid_b, tx_data_b, busy_b} !== '0) begin
         errors++;
         $display("FAIL async_reset: got data %h valid %0b busy %0b value %0d, required all 0",
                  tx_data_a, tx_valid_a, busy_a, bcd_value_a);
      end
      exp_a.delete();
      exp_b.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (bcd_start_a !== 1'b0 || busy_a !== 1'b0 || tx_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL no_resume: got start %0b busy %0b valid %0b, required 0 0 0", bcd_start_a, busy_a, tx_valid_a);
      end
      base = xfer_a;
      push_frame(81);
      pulse_update(8'd81);
      wait_frame(200);
      checks++;
      if (xfer_a - base !== 14) begin
         errors++;
         $display("FAIL fresh_frame: got %0d transfers, required 14", xfer_a - base);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_leading_blank();
      test_clamp();
      test_backpressure();
      test_back_to_back();
      test_fin_update();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
